// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter sharing one UART TX engine
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic                      abort_pulse
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] START     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]        state;
    logic [ID_W-1:0]   ptr;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [CNT_W-1:0]  stall_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              timeout_hit;
    logic              accept;
    logic [ID_W-1:0]   next_ptr;

    // Circular search starting at the rotation pointer; first asserted index wins.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[grant_id*DATA_W +: DATA_W];

    // A revoked grant must not accept a byte that shows up in the revoke cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == SEND) && (stall_cnt >= TIMEOUT_VAL);
    assign accept      = (state == SEND) && !timeout_hit && !tx_busy && sel_valid;
    assign req_ready   = accept ? (NUM_REQ'(1) << grant_id) : '0;

    assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign tx_start    = (state == START);
    assign tx_data     = data_q;
    assign abort_pulse = timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (timeout_hit) begin
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else if (accept) begin
                        data_q    <= sel_data;
                        last_q    <= sel_last;
                        stall_cnt <= '0;
                        state     <= START;
                    end else if (!sel_valid && (stall_cnt != '1)) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant_valid <= 1'b0;
                            ptr         <= next_ptr;
                            state       <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int DATA_W   = 8;
    localparam int TIMEOUT  = 20;
    localparam int BUSY_LEN = 10;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      grant_valid;
    logic [1:0]                grant_id;
    logic                      abort_pulse;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .abort_pulse(abort_pulse)
    );

    // TX engine model: busy for BUSY_LEN cycles starting the cycle after tx_start.
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    logic [8:0] src_mem [NUM_REQ][8];
    int         src_len  [NUM_REQ];
    int         src_idx  [NUM_REQ];
    int         src_stop [NUM_REQ];

    logic [7:0] log_data [32];
    int         log_gid  [32];
    int         log_cyc  [32];
    int         log_n = 0;
    int         abort_n = 0;
    int         abort_cyc = 0;
    int         cyc = 0;

    logic             gv_s, ts_s, busy_s, ab_s;
    logic [1:0]       gid_s;
    logic [2:0]       rdy_s;
    logic [7:0]       td_s;

    task automatic drive_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_idx[i] < src_len[i] && src_idx[i] < src_stop[i]) begin
                req_valid[i]            = 1'b1;
                req_data[i*DATA_W +: 8] = src_mem[i][src_idx[i]][7:0];
                req_last[i]             = src_mem[i][src_idx[i]][8];
            end else begin
                req_valid[i]            = 1'b0;
                req_data[i*DATA_W +: 8] = 8'h00;
                req_last[i]             = 1'b0;
            end
        end
    endtask

    task automatic load_src(input int i, input int n, input logic [8:0] b [8]);
        for (int k = 0; k < 8; k++) src_mem[i][k] = b[k];
        src_len[i]  = n;
        src_idx[i]  = 0;
        src_stop[i] = 8;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i]  = 0;
            src_idx[i]  = 0;
            src_stop[i] = 8;
        end
        log_n   = 0;
        abort_n = 0;
        drive_lanes();
    endtask

    // One clock: sample mid-cycle, then advance sources just after the edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        gv_s = grant_valid; gid_s = grant_id; rdy_s = req_ready;
        ts_s = tx_start; td_s = tx_data; busy_s = tx_busy; ab_s = abort_pulse;
        if (ts_s && log_n < 32) begin
            log_data[log_n] = td_s;
            log_gid[log_n]  = int'(gid_s);
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        if (ab_s) begin
            abort_n++;
            abort_cyc = cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (rdy_s[i]) src_idx[i]++;
        drive_lanes();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_all();
        run(2);
        reset = 1'b0;
        run(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_all();
        @(negedge clk);
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got %0b want 0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got start=%0b data=%h want 0/00", tx_start, tx_data); end
        checks++; if (abort_pulse !== 1'b0) begin errors++; $display("FAIL reset_abort got %0b want 0", abort_pulse); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2);
        checks++; if (gv_s !== 1'b0 || rdy_s !== 3'b000) begin errors++; $display("FAIL post_reset_idle got gv=%0b rdy=%b want 0/000", gv_s, rdy_s); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        int gid_bad;
        exp_d = '{8'h41, 8'h42, 8'h43};
        gid_bad = 0;
        clear_all();
        load_src(0, 3, '{9'h041, 9'h042, 9'h143, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        step();
        checks++; if (gv_s !== 1'b0) begin errors++; $display("FAIL single_idle_cycle gv got %0b want 0", gv_s); end
        step();
        checks++; if (gv_s !== 1'b1 || gid_s !== 2'd0 || rdy_s !== 3'b001) begin errors++; $display("FAIL single_grant_latency got gv=%0b gid=%0d rdy=%b want 1/0/001", gv_s, gid_s, rdy_s); end
        step();
        checks++; if (ts_s !== 1'b1 || td_s !== 8'h41) begin errors++; $display("FAIL single_start_latency got start=%0b data=%h want 1/41", ts_s, td_s); end
        for (int k = 0; k < 60; k++) begin
            step();
            if (gv_s && gid_s !== 2'd0) gid_bad++;
        end
        checks++; if (log_n !== 3) begin errors++; $display("FAIL single_count got %0d want 3", log_n); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (log_data[k] !== exp_d[k] || log_gid[k] !== 0) begin errors++; $display("FAIL single_byte%0d got %h/id%0d want %h/id0", k, log_data[k], log_gid[k], exp_d[k]); end
        end
        checks++; if (log_cyc[1] - log_cyc[0] !== 13) begin errors++; $display("FAIL single_byte_period got %0d want 13", log_cyc[1] - log_cyc[0]); end
        checks++; if (gid_bad !== 0) begin errors++; $display("FAIL single_holder_stable got %0d changes want 0", gid_bad); end
        checks++; if (gv_s !== 1'b0) begin errors++; $display("FAIL single_release got gv=%0b want 0", gv_s); end
    endtask

    task automatic test_ptr_after_release();
        clear_all();
        load_src(0, 1, '{9'h155, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        load_src(1, 1, '{9'h166, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        run(40);
        checks++; if (log_n !== 2) begin errors++; $display("FAIL ptr_count got %0d want 2", log_n); end
        checks++; if (log_data[0] !== 8'h66 || log_gid[0] !== 1) begin errors++; $display("FAIL ptr_first got %h/id%0d want 66/id1", log_data[0], log_gid[0]); end
        checks++; if (log_data[1] !== 8'h55 || log_gid[1] !== 0) begin errors++; $display("FAIL ptr_second got %h/id%0d want 55/id0", log_data[1], log_gid[1]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [8];
        int         exp_g [8];
        exp_d = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
        exp_g = '{0, 0, 1, 1, 2, 2, 0, 0};
        apply_reset();
        load_src(0, 4, '{9'h010, 9'h111, 9'h012, 9'h113, 9'h0, 9'h0, 9'h0, 9'h0});
        load_src(1, 2, '{9'h020, 9'h121, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        load_src(2, 2, '{9'h030, 9'h131, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        run(150);
        checks++; if (log_n !== 8) begin errors++; $display("FAIL rr_count got %0d want 8", log_n); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (log_data[k] !== exp_d[k] || log_gid[k] !== exp_g[k]) begin errors++; $display("FAIL rr_byte%0d got %h/id%0d want %h/id%0d", k, log_data[k], log_gid[k], exp_d[k], exp_g[k]); end
        end
    endtask

    task automatic test_timeout();
        int       armed;
        logic     rdy_at_abort;
        armed = 0;
        rdy_at_abort = 1'b1;
        clear_all();
        load_src(1, 3, '{9'h050, 9'h051, 9'h152, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        src_stop[1] = 1;
        load_src(2, 1, '{9'h160, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        for (int k = 0; k < 120; k++) begin
            step();
            if (armed == 0 && log_n >= 1 && cyc == log_cyc[0] + 31) begin
                src_stop[1] = 3;
                drive_lanes();
                armed = 1;
            end else if (armed == 1) begin
                rdy_at_abort = rdy_s[1];
                src_stop[1] = 1;
                drive_lanes();
                armed = 2;
            end
        end
        checks++; if (abort_n !== 1) begin errors++; $display("FAIL timeout_abort_count got %0d want 1", abort_n); end
        checks++; if (abort_cyc - log_cyc[0] !== 32) begin errors++; $display("FAIL timeout_abort_delay got %0d want 32", abort_cyc - log_cyc[0]); end
        checks++; if (rdy_at_abort !== 1'b0) begin errors++; $display("FAIL timeout_late_ready got %0b want 0", rdy_at_abort); end
        checks++; if (log_n !== 2) begin errors++; $display("FAIL timeout_tx_count got %0d want 2", log_n); end
        checks++; if (log_data[0] !== 8'h50 || log_gid[0] !== 1) begin errors++; $display("FAIL timeout_first got %h/id%0d want 50/id1", log_data[0], log_gid[0]); end
        checks++; if (log_data[1] !== 8'h60 || log_gid[1] !== 2) begin errors++; $display("FAIL timeout_next_holder got %h/id%0d want 60/id2", log_data[1], log_gid[1]); end
    endtask

    task automatic test_busy_hold();
        int early;
        early = 0;
        clear_all();
        force_busy = 1'b1;
        load_src(2, 1, '{9'h170, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        step();
        step();
        checks++; if (gv_s !== 1'b1 || gid_s !== 2'd2) begin errors++; $display("FAIL busy_grant got gv=%0b id=%0d want 1/2", gv_s, gid_s); end
        checks++; if (rdy_s !== 3'b000) begin errors++; $display("FAIL busy_ready_first got %b want 000", rdy_s); end
        for (int k = 0; k < 4; k++) begin
            step();
            if (rdy_s !== 3'b000) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL busy_ready_held got %0d early cycles want 0", early); end
        force_busy = 1'b0;
        step();
        checks++; if (rdy_s !== 3'b100) begin errors++; $display("FAIL busy_accept got %b want 100", rdy_s); end
        step();
        checks++; if (ts_s !== 1'b1 || td_s !== 8'h70) begin errors++; $display("FAIL busy_start got %0b/%h want 1/70", ts_s, td_s); end
        run(20);
    endtask

    task automatic test_reset_mid();
        int bad_rdy;
        int first_rdy;
        int waited;
        bad_rdy = 0;
        first_rdy = 0;
        waited = 0;
        clear_all();
        load_src(1, 1, '{9'h191, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        run(20);
        checks++; if (log_n !== 1 || log_data[0] !== 8'h91) begin errors++; $display("FAIL rstmid_setup got n=%0d data=%h want 1/91", log_n, log_data[0]); end
        log_n = 0;
        load_src(2, 2, '{9'h080, 9'h181, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        drive_lanes();
        while (log_n == 0 && waited < 10) begin
            step();
            waited++;
        end
        checks++; if (log_n !== 1 || log_data[0] !== 8'h80) begin errors++; $display("FAIL rstmid_first_byte got n=%0d data=%h want 1/80", log_n, log_data[0]); end
        run(2);
        load_src(1, 1, '{9'h192, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0});
        src_idx[2] = 1;
        drive_lanes();
        #4;
        reset = 1'b1;
        #1;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_grant got gv=%0b id=%0d want 0/0", grant_valid, grant_id); end
        checks++; if (tx_data !== 8'h00 || tx_start !== 1'b0 || req_ready !== 3'b000 || abort_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got data=%h start=%0b rdy=%b abort=%0b want 00/0/000/0", tx_data, tx_start, req_ready, abort_pulse); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        log_n = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (rdy_s !== 3'b000 && busy_s) bad_rdy++;
            if (rdy_s !== 3'b000 && first_rdy == 0) first_rdy = cyc;
        end
        checks++; if (bad_rdy !== 0 || first_rdy == 0) begin errors++; $display("FAIL rstmid_ready_vs_busy got bad=%0d seen=%0d want 0/nonzero", bad_rdy, first_rdy); end
        checks++; if (log_n < 1 || log_data[0] !== 8'h92 || log_gid[0] !== 1) begin errors++; $display("FAIL rstmid_regrant got n=%0d %h/id%0d want 92/id1", log_n, log_data[0], log_gid[0]); end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single();
        test_ptr_after_release();
        test_round_robin();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
